hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255, max MEM_WAIT cycles before forced release.
REQ-002 Parameter CNT_W, default 16, width of stall_cycles.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 id_valid  in  1  valid instruction in ID.
REQ-006 id_rs1, id_rs2  in  5 each  ID source registers.
REQ-007 id_use_rs1, id_use_rs2  in  1 each  source actually read.
REQ-008 ex_we, ex_is_load  in  1 each; ex_wa  in  5: EX instruction writes / is load / dest.
REQ-009 mem_we  in  1; mem_wa  in  5: MEM instruction writes / dest.
REQ-010 redirect  in  1  taken branch/jump resolved in EX; held by EX while EX stalled.
REQ-011 mem_req  in  1  MEM stage issues data access; mem_ack  in  1  data memory done.
REQ-012 stall_fd  out  1  hold PC and IF/ID register.
REQ-013 flush_id  out  1  clear IF/ID to NOP.
REQ-014 bubble_ex  out  1  load NOP into ID/EX.
REQ-015 stall_exm  out  1  hold ID/EX and EX/MEM registers.
REQ-016 bubble_wb  out  1  load NOP into MEM/WB.
REQ-017 fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB, 11 unused.
REQ-018 mem_timeout  out  1  sticky error flag.
REQ-019 stall_cycles  out  CNT_W  count of stall_fd cycles.

Function
REQ-020 FSM states RUN, MEM_WAIT; stall/flush/bubble outputs combinational from state and inputs; fwd_*, mem_timeout, stall_cycles registered.
REQ-021 mem_hold = (RUN & mem_req & !mem_ack) | (MEM_WAIT & !mem_ack & !tmo_hit); mem_hold asserts stall_fd, stall_exm, bubble_wb; all other outputs' actions suppressed.
REQ-022 RUN -> MEM_WAIT when mem_req & !mem_ack; MEM_WAIT -> RUN on mem_ack or tmo_hit; zero-wait access (req & ack same cycle) causes no stall.
REQ-023 Wait counter clears on MEM_WAIT entry, increments per MEM_WAIT cycle; tmo_hit = counter == MEM_TIMEOUT-1 & !mem_ack; tmo_hit sets mem_timeout, releases as if acked.
REQ-024 Redirect (no mem_hold): flush_id=1, bubble_ex=1, stall_fd=0, one cycle per redirect cycle; overrides load-use.
REQ-025 Load-use (no mem_hold, no redirect): id_valid & ex_is_load & ex_we & ex_wa!=0 & ((id_use_rs1 & id_rs1==ex_wa) | (id_use_rs2 & id_rs2==ex_wa)) -> stall_fd=1, bubble_ex=1 that cycle.
REQ-026 Priority: mem_hold > redirect > load-use > advance.
REQ-027 Advance cycle (none of above): fwd_a <= 01 if ex_we & !ex_is_load & ex_wa!=0 & ex_wa==id_rs1 & id_use_rs1; else 10 if mem_we & mem_wa!=0 & mem_wa==id_rs1 & id_use_rs1; else 00; fwd_b same with rs2; EX match beats MEM.
REQ-028 bubble_ex cycle: fwd_a, fwd_b <= 00; mem_hold cycle: fwd_* hold.
REQ-029 Register x0 never matches for stall or forwarding.
REQ-030 stall_cycles increments each stall_fd=1 cycle, saturates at all-ones, no wrap.
REQ-031 id_valid=0: no load-use stall; fwd_* computed per REQ-027.

Reset
REQ-032 rst_n=0 asynchronously forces: state RUN, wait counter 0, fwd_a=fwd_b=00, mem_timeout=0, stall_cycles=0.
REQ-033 During reset, combinational outputs follow RUN with inputs; mem_timeout cleared only by reset.
REQ-034 Reset asserted in MEM_WAIT aborts wait; after release, RUN, mem_hold re-evaluates.

Verification
REQ-035 lw x5 in EX, ID add x6,x5,x1 -> cycle 1: stall_fd=1, bubble_ex=1; next advance fwd_a=10.
REQ-036 add x5 in EX, ID sub uses x5 as rs2, MEM also writes x5 -> fwd_b=01; ex_wa=0 with rs=0 -> fwd 00.
REQ-037 mem_req=1, mem_ack after 3 cycles -> stall_fd, stall_exm, bubble_wb high 3 cycles, low on ack cycle, stall_cycles=3.
REQ-038 MEM_TIMEOUT=4, mem_req held, no ack -> 4 stall cycles, mem_timeout=1 stays set, state RUN.
REQ-039 redirect and load-use same cycle -> flush_id=1, bubble_ex=1, stall_fd=0; redirect during MEM_WAIT -> no flush until release.
REQ-040 rst_n low mid-MEM_WAIT with stall_cycles=7, mem_timeout=1 -> immediately all registers zero, state RUN.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stalls with timeout, redirect flushes,
// load-use interlock and EX operand forwarding selects.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_we,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_wa,
  input  logic             mem_we,
  input  logic [4:0]       mem_wa,
  input  logic             redirect,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             stall_fd,
  output logic             flush_id,
  output logic             bubble_ex,
  output logic             stall_exm,
  output logic             bubble_wb,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic {
    RUN,
    MEM_WAIT
  } state_t;

  state_t        state;
  logic [TW-1:0] wait_cnt;
  logic          tmo_hit;
  logic          mem_hold;
  logic          redir_act;
  logic          lu_hit;
  logic          load_use;
  logic [1:0]    fwd_a_nxt;
  logic [1:0]    fwd_b_nxt;

  // Forwarding source for one operand; a non-load EX result beats MEM, x0 never matches.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic use_rs,
                                         input logic exw, input logic exl, input logic [4:0] exa,
                                         input logic mw, input logic [4:0] ma);
    logic [1:0] sel;
    sel = 2'b00;
    if (use_rs && rs != 5'd0) begin
      if (exw && !exl && exa == rs)
        sel = 2'b01;
      else if (mw && ma == rs)
        sel = 2'b10;
    end
    return sel;
  endfunction

  always_comb begin
    tmo_hit  = (state == MEM_WAIT) && (wait_cnt == TW'(MEM_TIMEOUT - 1)) && !mem_ack;
    mem_hold = (state == RUN) ? (mem_req && !mem_ack) : (!mem_ack && !tmo_hit);
  end

  always_comb begin
    lu_hit = id_valid && ex_is_load && ex_we && (ex_wa != 5'd0) &&
             ((id_use_rs1 && id_rs1 == ex_wa) || (id_use_rs2 && id_rs2 == ex_wa));
    redir_act = !mem_hold && redirect;
    load_use  = !mem_hold && !redirect && lu_hit;
  end

  always_comb begin
    stall_fd  = mem_hold || load_use;
    flush_id  = redir_act;
    bubble_ex = redir_act || load_use;
    stall_exm = mem_hold;
    bubble_wb = mem_hold;
  end

  always_comb begin
    fwd_a_nxt = fwd_sel(id_rs1, id_use_rs1, ex_we, ex_is_load, ex_wa, mem_we, mem_wa);
    fwd_b_nxt = fwd_sel(id_rs2, id_use_rs2, ex_we, ex_is_load, ex_wa, mem_we, mem_wa);
  end

  // A timeout releases the wait exactly like an ack, but leaves the sticky error set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      wait_cnt     <= '0;
      fwd_a        <= 2'b00;
      fwd_b        <= 2'b00;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mem_req && !mem_ack) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (mem_ack || tmo_hit)
            state <= RUN;
          else
            wait_cnt <= wait_cnt + 1'b1;
        end
        default: state <= RUN;
      endcase

      if (tmo_hit)
        mem_timeout <= 1'b1;

      if (!mem_hold) begin
        if (bubble_ex) begin
          fwd_a <= 2'b00;
          fwd_b <= 2'b00;
        end else begin
          fwd_a <= fwd_a_nxt;
          fwd_b <= fwd_b_nxt;
        end
      end

      if (stall_fd && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus random traffic, checked
// against a cycle-level reference model of the hazard rules.
module tb_hazard_ctrl;

  localparam int TMO     = 4;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef struct packed {
    logic       idValid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic       exWe;
    logic       exLoad;
    logic [4:0] exWa;
    logic       memWe;
    logic [4:0] memWa;
    logic       redirect;
    logic       memReq;
    logic       memAck;
  } stim_t;

  typedef struct {
    int stallFd;
    int flushId;
    int bubbleEx;
    int stallExm;
    int bubbleWb;
    int fwdA;
    int fwdB;
    int tmo;
    int cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_use_rs1, id_use_rs2;
  logic [4:0]    id_rs1, id_rs2, ex_wa, mem_wa;
  logic          ex_we, ex_is_load, mem_we, redirect, mem_req, mem_ack;
  logic          stall_fd, flush_id, bubble_ex, stall_exm, bubble_wb, mem_timeout;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_cycles;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  // Reference model state: are we waiting on memory, for how long, and the visible registers.
  bit   mInWait;
  int   mWaitCnt;
  int   mFwdA, mFwdB, mTmo, mCnt;

  hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_we(ex_we), .ex_is_load(ex_is_load),
    .ex_wa(ex_wa), .mem_we(mem_we), .mem_wa(mem_wa), .redirect(redirect), .mem_req(mem_req),
    .mem_ack(mem_ack), .stall_fd(stall_fd), .flush_id(flush_id), .bubble_ex(bubble_ex),
    .stall_exm(stall_exm), .bubble_wb(bubble_wb), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic drive(input stim_t s);
    id_valid = s.idValid; id_rs1 = s.rs1; id_rs2 = s.rs2;
    id_use_rs1 = s.use1; id_use_rs2 = s.use2;
    ex_we = s.exWe; ex_is_load = s.exLoad; ex_wa = s.exWa;
    mem_we = s.memWe; mem_wa = s.memWa;
    redirect = s.redirect; mem_req = s.memReq; mem_ack = s.memAck;
  endtask

  function automatic int srcSel(input logic [4:0] rs, input logic useIt, input stim_t s);
    if (!useIt || rs == 0) return 0;
    if (s.exWe && !s.exLoad && s.exWa == rs) return 1;
    if (s.memWe && s.memWa == rs) return 2;
    return 0;
  endfunction

  function automatic bit loadUse(input stim_t s);
    if (!(s.idValid && s.exLoad && s.exWe && s.exWa != 0)) return 0;
    return (s.use1 && s.rs1 == s.exWa) || (s.use2 && s.rs2 == s.exWa);
  endfunction

  task automatic modelReset();
    mInWait = 0; mWaitCnt = 0; mFwdA = 0; mFwdB = 0; mTmo = 0; mCnt = 0;
  endtask

  // Queue the expected view of the current cycle; optionally advance the model one edge.
  task automatic predict(input stim_t s, input bit advance);
    exp_t e;
    bit   hitTmo, hold, redir, luse, stall;
    hitTmo = mInWait && (mWaitCnt == TMO - 1) && !s.memAck;
    hold   = mInWait ? (!s.memAck && !hitTmo) : (s.memReq && !s.memAck);
    redir  = !hold && s.redirect;
    luse   = !hold && !s.redirect && loadUse(s);
    stall  = hold || luse;
    e.stallFd = int'(stall); e.flushId = int'(redir); e.bubbleEx = int'(redir || luse);
    e.stallExm = int'(hold); e.bubbleWb = int'(hold);
    e.fwdA = mFwdA; e.fwdB = mFwdB; e.tmo = mTmo; e.cnt = mCnt;
    sb.push_back(e);
    if (advance) begin
      if (!hold) begin
        mFwdA = (redir || luse) ? 0 : srcSel(s.rs1, s.use1, s);
        mFwdB = (redir || luse) ? 0 : srcSel(s.rs2, s.use2, s);
      end
      if (hitTmo) mTmo = 1;
      if (stall && mCnt < CNT_MAX) mCnt++;
      if (!mInWait) begin
        if (s.memReq && !s.memAck) begin
          mInWait = 1;
          mWaitCnt = 0;
        end
      end else if (s.memAck || hitTmo) begin
        mInWait = 0;
      end else begin
        mWaitCnt++;
      end
    end
  endtask

  // Called 1 time unit after a rising edge; returns at the same point of the next cycle.
  task automatic applyStimulus(input stim_t s);
    drive(s);
    predict(s, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input stim_t s);
    drive(s);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_fwd_a", int'(fwd_a), 0);
    checkOutput("rst_fwd_b", int'(fwd_b), 0);
    checkOutput("rst_mem_timeout", int'(mem_timeout), 0);
    checkOutput("rst_stall_cycles", int'(stall_cycles), 0);
    modelReset();
    predict(s, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every cycle with a queued expectation is compared at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("stall_fd", int'(stall_fd), e.stallFd);
        checkOutput("flush_id", int'(flush_id), e.flushId);
        checkOutput("bubble_ex", int'(bubble_ex), e.bubbleEx);
        checkOutput("stall_exm", int'(stall_exm), e.stallExm);
        checkOutput("bubble_wb", int'(bubble_wb), e.bubbleWb);
        checkOutput("fwd_a", int'(fwd_a), e.fwdA);
        checkOutput("fwd_b", int'(fwd_b), e.fwdB);
        checkOutput("mem_timeout", int'(mem_timeout), e.tmo);
        checkOutput("stall_cycles", int'(stall_cycles), e.cnt);
      end
    end
  end

  initial begin
    stim_t s;
    int    guard;
    s = '0;
    rst_n = 1'b0;
    drive(s);
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Memory access acked after three wait cycles.
    s = '0; s.memReq = 1;
    repeat (3) applyStimulus(s);
    s.memAck = 1;
    applyStimulus(s);
    checkOutput("mem_wait_stalls", int'(stall_cycles), 3);
    s = '0;
    applyStimulus(s);

    // lw x5 in EX, add x6,x5,x1 in ID; then the load sits in MEM.
    s = '0; s.idValid = 1; s.rs1 = 5; s.use1 = 1; s.rs2 = 1; s.use2 = 1;
    s.exWe = 1; s.exLoad = 1; s.exWa = 5;
    applyStimulus(s);
    s.exWe = 0; s.exLoad = 0; s.exWa = 0; s.memWe = 1; s.memWa = 5;
    applyStimulus(s);
    checkOutput("load_use_fwd_a", int'(fwd_a), 2);

    // EX and MEM both write x5, ID reads it as rs2: EX wins.
    s = '0; s.idValid = 1; s.rs2 = 5; s.use2 = 1; s.use1 = 1;
    s.exWe = 1; s.exWa = 5; s.memWe = 1; s.memWa = 5;
    applyStimulus(s);
    checkOutput("ex_beats_mem_fwd_b", int'(fwd_b), 1);
    s.rs2 = 0; s.exWa = 0; s.memWa = 0;
    applyStimulus(s);
    checkOutput("x0_fwd_b", int'(fwd_b), 0);

    // Request never acked: timeout after four stalled cycles.
    s = '0; s.memReq = 1;
    repeat (5) applyStimulus(s);
    s = '0;
    applyStimulus(s);
    checkOutput("timeout_flag", int'(mem_timeout), 1);
    checkOutput("timeout_stalls", int'(stall_cycles), 8);

    // Redirect beats load-use; redirect during a wait only acts on release.
    s = '0; s.redirect = 1; s.idValid = 1; s.rs1 = 3; s.use1 = 1;
    s.exWe = 1; s.exLoad = 1; s.exWa = 3;
    applyStimulus(s);
    s = '0; s.memReq = 1; s.redirect = 1;
    repeat (2) applyStimulus(s);
    s.memAck = 1;
    applyStimulus(s);
    s = '0;
    applyStimulus(s);

    // Reset in the middle of a memory wait.
    s = '0; s.memReq = 1;
    repeat (2) applyStimulus(s);
    s = '0;
    doReset(s);
    applyStimulus(s);

    // Random traffic over a small register set so hazards are frequent.
    for (int i = 0; i < 3000; i++) begin
      s.idValid = 1'($urandom_range(0, 3) != 0);
      s.rs1 = 5'($urandom_range(0, 3));
      s.rs2 = 5'($urandom_range(0, 3));
      s.use1 = 1'($urandom_range(0, 1));
      s.use2 = 1'($urandom_range(0, 1));
      s.exWe = 1'($urandom_range(0, 3) != 0);
      s.exLoad = 1'($urandom_range(0, 2) == 0);
      s.exWa = 5'($urandom_range(0, 3));
      s.memWe = 1'($urandom_range(0, 1));
      s.memWa = 5'($urandom_range(0, 3));
      s.redirect = 1'($urandom_range(0, 6) == 0);
      s.memReq = 1'($urandom_range(0, 2) == 0);
      s.memAck = 1'($urandom_range(0, 4) < 2);
      if ($urandom_range(0, 199) == 0)
        doReset(s);
      else
        applyStimulus(s);
    end

    s = '0;
    applyStimulus(s);
    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (sb.size() > 0)
      checkOutput("scoreboard_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
